conv_encoder_framed: RTL and testbench

Parametrised rate-1/N feed-forward convolutional encoder with frame control and automatic trellis termination. It accepts a frame of L message bits over a valid/ready handshake and emits one N-bit codeword per input bit. It then appends K-1 internally generated zero tail bits so the encoder ends in the all-zero state. It sits between the message source and the modulator/interleaver and generalises the earlier fixed K=3, rate-1/2 encoder.

---
 rtl/conv_encoder_framed_pkg.sv | 27 ++
 rtl/conv_encoder_framed_if.sv | 28 ++
 rtl/conv_encoder_framed_core.sv | 36 +++
 rtl/conv_encoder_framed.sv | 119 +++++++++++
 tb/tb_conv_encoder_framed.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_encoder_framed_pkg.sv
// Shared types and constants for the framed convolutional encoder.
package conv_enc_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        DATA  = S_DATA,
        TAIL  = S_TAIL,
        DRAIN = S_DRAIN
    } state_t;

    // Standard generator sets; the low K bits are G[0] and drive out_bits[0].
    localparam logic [5:0]  G_K3 = {3'b101, 3'b111};
    localparam logic [13:0] G_K7 = {7'b1011011, 7'b1111001};

    localparam int MAX_K = 9;

    function automatic logic parity_taps(input logic [MAX_K-1:0] poly,
                                         input logic [MAX_K-1:0] taps);
        return ^(poly & taps);
    endfunction

endpackage

// File: rtl/conv_encoder_framed_if.sv
// Frame control and input/output handshake bundle of the framed encoder.
interface conv_encoder_framed_if #(
    parameter int N_OUT = 2,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic [N_OUT-1:0] out_bits;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic             zeroed;
    logic             done;

    modport master (
        output start, frame_len, in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bits, out_last, busy, zeroed, done
    );

    modport slave (
        input  start, frame_len, in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bits, out_last, busy, zeroed, done
    );
endinterface

// File: rtl/conv_encoder_framed_core.sv
// Encoder shift register and the N_OUT generator parity taps.
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter int                 K     = 3,
    parameter int                 N_OUT = 2,
    parameter logic [N_OUT*K-1:0] G     = G_K3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             enc_bit,
    output logic [N_OUT-1:0] codeword,
    output logic             zeroed
);
    // sr[K-2] holds the newest bit, sr[0] the oldest.
    logic [K-2:0] sr;

    always_ff @(posedge clk) begin
        if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= {enc_bit, sr[K-2:1]};
        end
    end

    always_comb begin
        codeword = '0;
        for (int i = 0; i < N_OUT; i++) begin
            codeword[i] = parity_taps(MAX_K'(G[i*K +: K]), MAX_K'({enc_bit, sr}));
        end
    end

    assign zeroed = (sr == '0);

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/N_OUT convolutional encoder: frame FSM, counters, output slot and handshakes.
// Every frame is followed by K-1 zero tail bits so the trellis ends in the all-zero state.
module conv_encoder_framed
    import conv_enc_pkg::*;
#(
    parameter int                 K     = 3,
    parameter int                 N_OUT = 2,
    parameter logic [N_OUT*K-1:0] G     = G_K3,
    parameter int                 LEN_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    conv_encoder_framed_if.slave bus
);
    localparam int TCNT_W = $clog2(K);

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [TCNT_W-1:0] tcnt;
    logic              out_valid;
    logic              out_last;
    logic [N_OUT-1:0]  out_bits;
    logic [N_OUT-1:0]  codeword;
    logic              slot_free;
    logic              in_ready;
    logic              accept;
    logic              tail_load;
    logic              load;
    logic              enc_bit;
    logic              clear;
    logic              zeroed;

    assign slot_free = !out_valid || bus.out_ready;
    assign in_ready  = !reset && (state == DATA) && slot_free;
    assign accept    = in_ready && bus.in_valid;
    assign tail_load = !reset && (state == TAIL) && slot_free;
    assign load      = accept || tail_load;
    assign enc_bit   = accept ? bus.in_bit : 1'b0;
    assign clear     = reset || ((state == IDLE) && bus.start);

    conv_enc_core #(
        .K     (K),
        .N_OUT (N_OUT),
        .G     (G)
    ) u_core (
        .clk      (clk),
        .clear    (clear),
        .load     (load),
        .enc_bit  (enc_bit),
        .codeword (codeword),
        .zeroed   (zeroed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            tcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt   <= bus.frame_len;
                        tcnt  <= TCNT_W'(K-1);
                        state <= (bus.frame_len != '0) ? DATA : TAIL;
                    end
                end
                DATA: begin
                    if (accept) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            tcnt  <= TCNT_W'(K-1);
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (tail_load) begin
                        tcnt <= tcnt - TCNT_W'(1);
                        if (tcnt == TCNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load into a free slot wins over the handshake that freed it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_bits  <= codeword;
            out_last  <= tail_load && (tcnt == TCNT_W'(1));
        end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bits  = out_bits;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state != IDLE);
    assign bus.zeroed    = zeroed;
    assign bus.done      = !reset && (state == DRAIN) && out_valid && bus.out_ready;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Drives a K=3 and a K=7 encoder with identical frames and checks both against a convolution model.
module tb_conv_encoder_framed;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] frame_len;
    logic       in_valid [2];
    logic       in_bit   [2];
    logic       out_ready;

    logic       ir  [2];
    logic       ov  [2];
    logic       ol  [2];
    logic       bsy [2];
    logic       zr  [2];
    logic       dn  [2];
    logic [1:0] ob  [2];

    int checks = 0;
    int errors = 0;

    bit msg [$];
    int pos   [2];
    int got   [2];
    int total [2];
    bit fin   [2];

    logic [1:0] tbl [7] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11};
    logic       ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    conv_encoder_framed_if #(.N_OUT(2), .LEN_W(8)) bus3 ();
    conv_encoder_framed_if #(.N_OUT(2), .LEN_W(8)) bus7 ();

    assign bus3.start     = start;
    assign bus3.frame_len = frame_len;
    assign bus3.in_valid  = in_valid[0];
    assign bus3.in_bit    = in_bit[0];
    assign bus3.out_ready = out_ready;
    assign bus7.start     = start;
    assign bus7.frame_len = frame_len;
    assign bus7.in_valid  = in_valid[1];
    assign bus7.in_bit    = in_bit[1];
    assign bus7.out_ready = out_ready;

    assign ir[0] = bus3.in_ready;   assign ir[1] = bus7.in_ready;
    assign ov[0] = bus3.out_valid;  assign ov[1] = bus7.out_valid;
    assign ol[0] = bus3.out_last;   assign ol[1] = bus7.out_last;
    assign bsy[0] = bus3.busy;      assign bsy[1] = bus7.busy;
    assign zr[0] = bus3.zeroed;     assign zr[1] = bus7.zeroed;
    assign dn[0] = bus3.done;       assign dn[1] = bus7.done;
    assign ob[0] = bus3.out_bits;   assign ob[1] = bus7.out_bits;

    conv_encoder_framed #(
        .K(3), .N_OUT(2), .G({3'b101, 3'b111}), .LEN_W(8)
    ) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave)
    );

    conv_encoder_framed #(
        .K(7), .N_OUT(2), .G({7'b1011011, 7'b1111001}), .LEN_W(8)
    ) dut7 (
        .clk(clk), .reset(reset), .bus(bus7.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Word j is the convolution of the zero-padded message with each generator:
    // polynomial bit K-1-t weights message bit j-t.
    function automatic logic [1:0] modelWord(input int d, input int j);
        int          k;
        int          idx;
        logic [13:0] g;
        logic [1:0]  w;
        k = (d == 0) ? 3 : 7;
        g = (d == 0) ? 14'b00000000101111 : 14'b10110111111001;
        w = '0;
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < k; t++) begin
                idx = j - t;
                if (idx >= 0 && idx < msg.size() && g[i*k + k-1-t]) begin
                    w[i] = w[i] ^ msg[idx];
                end
            end
        end
        return w;
    endfunction

    task automatic checkIdleOutputs(input string phase);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s_d%0d_in_ready", phase, d), ir[d], 0);
            checkOutput($sformatf("%s_d%0d_out_valid", phase, d), ov[d], 0);
            checkOutput($sformatf("%s_d%0d_out_bits", phase, d), ob[d], 0);
            checkOutput($sformatf("%s_d%0d_out_last", phase, d), ol[d], 0);
            checkOutput($sformatf("%s_d%0d_busy", phase, d), bsy[d], 0);
            checkOutput($sformatf("%s_d%0d_done", phase, d), dn[d], 0);
            checkOutput($sformatf("%s_d%0d_zeroed", phase, d), zr[d], 1);
        end
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic applyStimulus(input int ready_mode, input bit glitch, input bit idle_valid,
                                 input bit use_table);
        int         len;
        int         cycles;
        bit         hs;
        logic [1:0] exp_word;
        len = msg.size();
        for (int d = 0; d < 2; d++) begin
            pos[d]   = 0;
            got[d]   = 0;
            fin[d]   = 0;
            total[d] = len + ((d == 0) ? 2 : 6);
        end
        @(negedge clk);
        start       = 1'b1;
        frame_len   = 8'(len);
        in_valid[0] = idle_valid;
        in_valid[1] = idle_valid;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (!(fin[0] && fin[1]) && cycles < 2000) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ready_pat[cycles % 4];
                default: out_ready = 1'($urandom_range(1));
            endcase
            for (int d = 0; d < 2; d++) begin
                if (pos[d] < len) begin
                    in_valid[d] = (ready_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
                    in_bit[d]   = msg[pos[d]];
                end else begin
                    in_valid[d] = idle_valid;
                    in_bit[d]   = 1'($urandom_range(1));
                end
            end
            start     = glitch && pos[0] < len && pos[1] < len && (cycles % 3 == 1);
            frame_len = 8'($urandom_range(255));
            #4;
            for (int d = 0; d < 2; d++) begin
                hs = ov[d] && out_ready;
                if (cycles == 0) checkOutput($sformatf("d%0d_first_in_ready", d), ir[d], (len != 0));
                if (ov[d] && !out_ready) checkOutput($sformatf("d%0d_backpressure_in_ready", d), ir[d], 0);
                if (pos[d] >= len) checkOutput($sformatf("d%0d_no_data_in_ready", d), ir[d], 0);
                checkOutput($sformatf("d%0d_done", d), dn[d], hs && !fin[d] && got[d] == total[d]-1);
                if (hs) begin
                    if (fin[d]) begin
                        checkOutput($sformatf("d%0d_extra_word", d), 1, 0);
                    end else begin
                        exp_word = (use_table && d == 0) ? tbl[got[d]] : modelWord(d, got[d]);
                        checkOutput($sformatf("d%0d_word%0d", d, got[d]), ob[d], exp_word);
                        checkOutput($sformatf("d%0d_last%0d", d, got[d]), ol[d], got[d] == total[d]-1);
                        if (got[d] == total[d]-1) fin[d] = 1;
                        got[d]++;
                    end
                end
                if (ir[d] && in_valid[d] && pos[d] < len) pos[d]++;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        if (!(fin[0] && fin[1])) checkOutput("frame_timeout", 0, 1);
        start       = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        out_ready   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("d%0d_post_zeroed", d), zr[d], 1);
            checkOutput($sformatf("d%0d_post_busy", d), bsy[d], 0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        frame_len   = '0;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        in_bit[0]   = 1'b0; in_bit[1]   = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;

        msg = '{1, 1, 0, 0, 1};
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        msg.delete();
        applyStimulus(0, 0, 1, 0);
        // K=7 impulse: out_bits[0] follows 1111001 and out_bits[1] follows 1011011.
        msg = '{1};
        applyStimulus(0, 0, 0, 0);

        // Abort a frame with reset on the third data bit.
        @(negedge clk);
        start = 1'b1; frame_len = 8'd6;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid[0] = 1'b1; in_valid[1] = 1'b1;
            in_bit[0] = (b != 1); in_bit[1] = (b != 1);
            if (b == 2) reset = 1'b1;
            @(negedge clk);
        end
        checkIdleOutputs("abort");
        reset = 1'b0;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;

        msg = '{1, 0, 1, 1, 0, 0, 1};
        applyStimulus(2, 1, 1, 0);

        for (int f = 0; f < 8; f++) begin
            msg.delete();
            for (int b = 0, n = $urandom_range(12); b < n; b++) msg.push_back(1'($urandom_range(1)));
            applyStimulus($urandom_range(2), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
